// File: rtl/bumpy_hit_edge_detector.sv
// Per-frame Bumpy/brick overlap detector: counts overlap pixels and records which sprite edge bands were hit.
// Results publish one cycle after each startOfFrame and hold for the frame; no backpressure, one pixel per clk.
module bumpy_hit_edge_detector #(
   parameter int OBJECT_SIZE = 32,
   parameter int EDGE_WIDTH  = 4,
   parameter int MIN_HITS    = 2
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic signed [10:0] pixelX,
   input  logic signed [10:0] pixelY,
   input  logic               bumpyDrawingRequest,
   input  logic               brickDrawingRequest,
   input  logic signed [10:0] topLeftX,
   input  logic signed [10:0] topLeftY,
   input  logic               EndGame,
   output logic               collision,
   output logic [3:0]         HitEdgeCode,
   output logic [7:0]         hitCount
);

   localparam logic signed [11:0] SZ   = 12'(OBJECT_SIZE);
   localparam logic signed [11:0] EW   = 12'(EDGE_WIDTH);
   localparam logic [8:0]         MINH = 9'(MIN_HITS);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t             state;
   logic [7:0]         counter;
   logic [3:0]         accum;
   logic signed [11:0] offX;
   logic signed [11:0] offY;
   logic               inX;
   logic               inY;
   logic               overlap;
   logic [3:0]         edge_bits;
   logic [7:0]         counter_inc;
   logic               qualifies;

   // 12-bit sign-extended subtraction so sprites near the screen edge never wrap
   assign offX = {pixelX[10], pixelX} - {topLeftX[10], topLeftX};
   assign offY = {pixelY[10], pixelY} - {topLeftY[10], topLeftY};
   assign inX  = (offX >= 12'sd0) && (offX < SZ);
   assign inY  = (offY >= 12'sd0) && (offY < SZ);

   assign overlap     = (state == ACCUM) && bumpyDrawingRequest && brickDrawingRequest;
   assign counter_inc = (counter == 8'hFF) ? counter : counter + 8'd1;
   assign qualifies   = {1'b0, counter} >= MINH;

   always_comb begin
      edge_bits = 4'b0000;
      if (inX && inY) begin
         edge_bits[0] = offY >= (SZ - EW);
         edge_bits[1] = offX >= (SZ - EW);
         edge_bits[2] = offY < EW;
         edge_bits[3] = offX < EW;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN || EndGame) begin
         state       <= IDLE;
         counter     <= 8'd0;
         accum       <= 4'b0000;
         collision   <= 1'b0;
         HitEdgeCode <= 4'b0000;
         hitCount    <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (startOfFrame)
                  state <= ACCUM;
            end
            ACCUM: begin
               if (startOfFrame) begin
                  collision   <= qualifies;
                  HitEdgeCode <= qualifies ? accum : 4'b0000;
                  hitCount    <= counter;
                  // a pixel landing on the frame boundary belongs to the new frame
                  counter     <= overlap ? 8'd1 : 8'd0;
                  accum       <= overlap ? edge_bits : 4'b0000;
               end else if (overlap) begin
                  counter <= counter_inc;
                  accum   <= accum | edge_bits;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bumpy_hit_edge_detector.sv
// Randomized and directed bench for bumpy_hit_edge_detector against a frame-level reference model.
module tb_bumpy_hit_edge_detector;

   localparam int SZ   = 32;
   localparam int EW   = 4;
   localparam int MINH = 2;

   logic               clk;
   logic               resetN;
   logic               startOfFrame;
   logic signed [10:0] pixelX;
   logic signed [10:0] pixelY;
   logic               bumpyDrawingRequest;
   logic               brickDrawingRequest;
   logic signed [10:0] topLeftX;
   logic signed [10:0] topLeftY;
   logic               EndGame;
   logic               collision;
   logic [3:0]         HitEdgeCode;
   logic [7:0]         hitCount;

   bumpy_hit_edge_detector #(.OBJECT_SIZE(SZ), .EDGE_WIDTH(EW), .MIN_HITS(MINH)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .pixelX(pixelX), .pixelY(pixelY),
      .bumpyDrawingRequest(bumpyDrawingRequest), .brickDrawingRequest(brickDrawingRequest),
      .topLeftX(topLeftX), .topLeftY(topLeftY), .EndGame(EndGame),
      .collision(collision), .HitEdgeCode(HitEdgeCode), .hitCount(hitCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: is a frame being gathered, what it has gathered, what is on display
   bit       m_inframe;
   int       m_cnt;
   bit [3:0] m_edges;
   bit       m_col;
   bit [3:0] m_code;
   int       m_hit;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic bit [3:0] edges_of(input int ox, input int oy);
      bit [3:0] e = 4'b0000;
      if (ox >= 0 && ox < SZ && oy >= 0 && oy < SZ) begin
         if (oy >= SZ - EW) e[0] = 1'b1;
         if (ox >= SZ - EW) e[1] = 1'b1;
         if (oy < EW)       e[2] = 1'b1;
         if (ox < EW)       e[3] = 1'b1;
      end
      return e;
   endfunction

   task automatic model_step();
      int ox, oy;
      if (!resetN || EndGame) begin
         m_inframe = 0; m_cnt = 0; m_edges = 0;
         m_col = 0; m_code = 0; m_hit = 0;
      end else if (!m_inframe) begin
         if (startOfFrame) m_inframe = 1;
      end else begin
         if (startOfFrame) begin
            m_hit  = m_cnt;
            m_col  = (m_cnt >= MINH);
            m_code = m_col ? m_edges : 4'b0000;
            m_cnt  = 0;
            m_edges = 0;
         end
         if (bumpyDrawingRequest && brickDrawingRequest) begin
            ox = int'(pixelX) - int'(topLeftX);
            oy = int'(pixelY) - int'(topLeftY);
            if (m_cnt < 255) m_cnt++;
            m_edges |= edges_of(ox, oy);
         end
      end
   endtask

   task automatic cyc(input bit sof, input bit bmp, input bit brk, input int px, input int py,
                      input bit eg, input bit rstn);
      startOfFrame        = sof;
      bumpyDrawingRequest = bmp;
      brickDrawingRequest = brk;
      pixelX              = 11'(px);
      pixelY              = 11'(py);
      EndGame             = eg;
      resetN              = rstn;
      model_step();
      @(posedge clk);
      #1;
      chk("collision", int'(collision), int'(m_col));
      chk("HitEdgeCode", int'(HitEdgeCode), int'(m_code));
      chk("hitCount", int'(hitCount), m_hit);
   endtask

   task automatic ovl(input int px, input int py);
      cyc(0, 1, 1, px, py, 0, 1);
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++)
         cyc(0, 1'($urandom_range(0, 1)), 0, int'(topLeftX) + 5, int'(topLeftY) + 5, 0, 1);
   endtask

   task automatic sof();
      cyc(1, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic expect_out(input string tag, input int c, input int e, input int h);
      chk({tag, "_col"}, int'(collision), c);
      chk({tag, "_edge"}, int'(HitEdgeCode), e);
      chk({tag, "_hit"}, int'(hitCount), h);
   endtask

   initial begin
      topLeftX = 11'sd100;
      topLeftY = 11'sd200;
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 100, 200, 0, 0);
      expect_out("reset", 0, 0, 0);

      // overlaps before the first frame start are ignored
      ovl(110, 229);
      sof();
      expect_out("first_sof", 0, 0, 0);

      // bottom band hits
      ovl(110, 229); gap(2); ovl(111, 230); ovl(112, 231); gap(3);
      sof();
      expect_out("bottom", 1, 4'b0001, 3);

      // single pixel below threshold
      ovl(131, 200); gap(4);
      sof();
      expect_out("single", 0, 0, 1);

      // opposite corners light all four bands
      ovl(100, 200); gap(1); ovl(131, 231);
      sof();
      expect_out("corners", 1, 4'b1111, 2);

      // out-of-range pixels count but mark nothing
      ovl(99, 210); ovl(140, 210); ovl(110, 199);
      sof();
      expect_out("outside", 1, 0, 3);

      // saturation, then an empty frame
      for (int i = 0; i < 300; i++) ovl(100 + (i % 32), 210);
      sof();
      expect_out("sat", 1, 4'b1010, 255);
      gap(10);
      sof();
      expect_out("empty", 0, 0, 0);

      // EndGame coincident with startOfFrame
      ovl(110, 229); ovl(111, 229); sof();
      ovl(101, 201); ovl(102, 202); ovl(103, 203); ovl(104, 204); ovl(105, 205);
      cyc(1, 1, 1, 110, 210, 1, 1);
      expect_out("endgame", 0, 0, 0);
      ovl(110, 229);
      sof();
      expect_out("eg_resume", 0, 0, 0);
      ovl(110, 229); ovl(110, 230); ovl(110, 231);
      sof();
      expect_out("eg_publish", 1, 4'b0001, 3);

      // reset mid-frame with pending overlaps
      ovl(101, 201); ovl(102, 202);
      cyc(0, 1, 1, 101, 201, 0, 0);
      expect_out("midreset", 0, 0, 0);
      ovl(110, 229);
      sof();
      expect_out("rst_resume", 0, 0, 0);
      ovl(100, 210); ovl(100, 211);
      sof();
      expect_out("rst_publish", 1, 4'b1000, 2);

      // overlap coincident with startOfFrame belongs to the new frame
      cyc(1, 1, 1, 131, 215, 0, 1);
      ovl(131, 216);
      sof();
      expect_out("sof_pixel", 1, 4'b0010, 2);

      // randomized frames with moving sprite and rare EndGame/reset
      for (int f = 0; f < 60; f++) begin
         cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'(topLeftX) + int'($urandom_range(0, 40)) - 4,
             int'(topLeftY) + int'($urandom_range(0, 40)) - 4, 0, 1);
         for (int i = 0; i < int'($urandom_range(5, 50)); i++) begin
            int r;
            bit bmp, brk;
            r = int'($urandom_range(0, 199));
            if ($urandom_range(0, 19) == 0) begin
               topLeftX = 11'(int'($urandom_range(0, 1100)) - 20);
               topLeftY = 11'(int'($urandom_range(0, 900)) - 20);
            end
            bmp = ($urandom_range(0, 9) < 6);
            brk = ($urandom_range(0, 9) < 6);
            cyc(r == 3, bmp, brk,
                int'(topLeftX) + int'($urandom_range(0, 40)) - 4,
                int'(topLeftY) + int'($urandom_range(0, 40)) - 4,
                r == 0, r != 1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
